// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Owns the fetch PC and the instruction-memory request port, and loads the
// IF/ID register. A one-entry buffer holds a response that lands during a
// stall. A DROP state discards a response whose request was redirected away.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PCSel,
    input  logic [31:0] NPC,
    input  logic [31:0] RS_D,
    input  logic        Flush,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC_F,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic        valid_D
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc_f;
    logic [31:0] pend;
    logic [31:0] ibuf;
    logic        ibuf_valid;

    logic        instr_avail;
    logic [31:0] instr;
    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // A request is outstanding whenever FETCH has nothing buffered, and
    // for the whole of DROP until the stale response shows up.
    assign imem_req  = (state == FETCH) ? !ibuf_valid : 1'b1;
    assign imem_addr = pc_f;
    assign PC_F      = pc_f;

    // The buffered word takes priority over a live response; redirect
    // targets are always word aligned.
    assign instr_avail = ibuf_valid | (imem_req & imem_ready);
    assign instr       = ibuf_valid ? ibuf : imem_rdata;
    assign redirect    = !Stall && ((PCSel == 2'd1) || (PCSel == 2'd2));
    assign target_raw  = (PCSel == 2'd1) ? NPC : RS_D;
    assign target      = target_raw & ~32'd3;
    assign pc_plus4    = pc_f + 32'd4;

    // Fetch state machine: PC, instruction buffer, pending target and the
    // IF/ID register all update together on the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc_f       <= RESET_PC;
            pend       <= 32'd0;
            ibuf       <= 32'd0;
            ibuf_valid <= 1'b0;
            IR_D       <= 32'd0;
            PC_D       <= 32'd0;
            PC4_D      <= 32'd0;
            valid_D    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (Stall) begin
                        if (imem_req && imem_ready) begin
                            ibuf       <= imem_rdata;
                            ibuf_valid <= 1'b1;
                        end
                    end else if (redirect) begin
                        IR_D    <= 32'd0;
                        valid_D <= 1'b0;
                        if (instr_avail) begin
                            pc_f       <= target;
                            ibuf_valid <= 1'b0;
                        end else begin
                            pend  <= target;
                            state <= DROP;
                        end
                    end else if (Flush) begin
                        IR_D    <= 32'd0;
                        valid_D <= 1'b0;
                        if (instr_avail) begin
                            pc_f       <= pc_plus4;
                            ibuf_valid <= 1'b0;
                        end
                    end else if (instr_avail) begin
                        IR_D       <= instr;
                        PC_D       <= pc_f;
                        PC4_D      <= pc_plus4;
                        valid_D    <= 1'b1;
                        pc_f       <= pc_plus4;
                        ibuf_valid <= 1'b0;
                    end else begin
                        IR_D    <= 32'd0;
                        valid_D <= 1'b0;
                    end
                end
                DROP: begin
                    if (!Stall) begin
                        IR_D    <= 32'd0;
                        valid_D <= 1'b0;
                    end
                    if (imem_ready) begin
                        pc_f  <= pend;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage. The instruction memory
// returns its own address as data so each IR_D value names its fetch PC.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [1:0]  PCSel;
    logic [31:0] NPC;
    logic [31:0] RS_D;
    logic        Flush;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] PC_F;
    logic [31:0] IR_D;
    logic [31:0] PC_D;
    logic [31:0] PC4_D;
    logic        valid_D;

    int checkCount;
    int failCount;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .PCSel      (PCSel),
        .NPC        (NPC),
        .RS_D       (RS_D),
        .Flush      (Flush),
        .Stall      (Stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .PC_F       (PC_F),
        .IR_D       (IR_D),
        .PC_D       (PC_D),
        .PC4_D      (PC4_D),
        .valid_D    (valid_D)
    );

    assign imem_rdata = imem_addr;

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance to 1 unit past the next edge.
    task automatic applyStimulus(input logic rst, input logic stl, input logic fl,
                                 input logic [1:0] sel, input logic [31:0] npc,
                                 input logic [31:0] rs, input logic rdy);
        reset      = rst;
        Stall      = stl;
        Flush      = fl;
        PCSel      = sel;
        NPC        = npc;
        RS_D       = rs;
        imem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Directed sequence; each step's expectations were worked out by hand.
    initial begin
        checkCount = 0;
        failCount  = 0;
        reset = 1'b1; Stall = 1'b0; Flush = 1'b0; PCSel = 2'd0;
        NPC = 32'd0; RS_D = 32'd0; imem_ready = 1'b1;

        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("rst_pc_f",   PC_F, 32'h3000);
        checkOutput("rst_ir_d",   IR_D, 32'h0);
        checkOutput("rst_valid",  {31'd0, valid_D}, 32'd0);
        checkOutput("rst_pc4_d",  PC4_D, 32'h0);
        checkOutput("rst_req",    {31'd0, imem_req}, 32'd1);
        checkOutput("rst_addr",   imem_addr, 32'h3000);

        // Zero-wait streaming
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("s1_ir_d",  IR_D, 32'h3000);
        checkOutput("s1_valid", {31'd0, valid_D}, 32'd1);
        checkOutput("s1_pc4_d", PC4_D, 32'h3004);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("s2_ir_d",  IR_D, 32'h3004);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("s3_ir_d",  IR_D, 32'h3008);
        checkOutput("s3_pc_d",  PC_D, 32'h3008);
        checkOutput("s3_pc4_d", PC4_D, 32'h300C);
        checkOutput("s3_pc_f",  PC_F, 32'h300C);

        // Stall with a response landing mid-stall
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("st1_pc_f", PC_F, 32'h300C);
        checkOutput("st1_ir_d", IR_D, 32'h3008);
        checkOutput("st1_req",  {31'd0, imem_req}, 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 0, 1);
        checkOutput("st2_req",  {31'd0, imem_req}, 32'd0);
        checkOutput("st2_pc_f", PC_F, 32'h300C);
        checkOutput("st2_ir_d", IR_D, 32'h3008);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("st3_pc_d",  PC_D, 32'h3008);
        checkOutput("st3_valid", {31'd0, valid_D}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("st4_ir_d", IR_D, 32'h300C);
        checkOutput("st4_pc_f", PC_F, 32'h3010);
        checkOutput("st4_req",  {31'd0, imem_req}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("st5_ir_d", IR_D, 32'h3010);

        // Branch redirect to an unaligned NPC, zero-wait memory
        applyStimulus(0, 0, 0, 1, 32'h4001, 0, 1);
        checkOutput("br1_ir_d",  IR_D, 32'h0);
        checkOutput("br1_valid", {31'd0, valid_D}, 32'd0);
        checkOutput("br1_pc_f",  PC_F, 32'h4000);
        checkOutput("br1_pc_d",  PC_D, 32'h3010);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("br2_ir_d",  IR_D, 32'h4000);
        checkOutput("br2_valid", {31'd0, valid_D}, 32'd1);
        checkOutput("br2_pc_f",  PC_F, 32'h4004);

        // JR redirect with memory three cycles late
        applyStimulus(0, 0, 0, 2, 0, 32'h5000, 0);
        checkOutput("jr1_ir_d", IR_D, 32'h0);
        checkOutput("jr1_pc_f", PC_F, 32'h4004);
        checkOutput("jr1_req",  {31'd0, imem_req}, 32'd1);
        applyStimulus(0, 0, 1, 1, 32'h6000, 0, 0);
        checkOutput("jr2_pc_f",  PC_F, 32'h4004);
        checkOutput("jr2_valid", {31'd0, valid_D}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("jr3_pc_f", PC_F, 32'h4004);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("jr4_pc_f", PC_F, 32'h5000);
        checkOutput("jr4_ir_d", IR_D, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("jr5_ir_d", IR_D, 32'h5000);
        checkOutput("jr5_pc_f", PC_F, 32'h5004);

        // Redirect while stalled is ignored until Stall drops
        applyStimulus(0, 1, 0, 1, 32'h7000, 0, 1);
        checkOutput("rs1_pc_f", PC_F, 32'h5004);
        checkOutput("rs1_ir_d", IR_D, 32'h5000);
        applyStimulus(0, 0, 0, 1, 32'h7000, 0, 1);
        checkOutput("rs2_pc_f",  PC_F, 32'h7000);
        checkOutput("rs2_valid", {31'd0, valid_D}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("rs3_ir_d", IR_D, 32'h7000);

        // Flush discards the instruction in IF
        applyStimulus(0, 0, 1, 0, 0, 0, 1);
        checkOutput("fl1_ir_d", IR_D, 32'h0);
        checkOutput("fl1_pc_f", PC_F, 32'h7008);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("fl2_ir_d", IR_D, 32'h7008);

        // PC wraps from FFFF_FFFC to 0
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
        checkOutput("wr1_pc_f", PC_F, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("wr2_ir_d",  IR_D, 32'hFFFF_FFFC);
        checkOutput("wr2_pc4_d", PC4_D, 32'h0);
        checkOutput("wr2_pc_f",  PC_F, 32'h0);

        // Reset while in DROP
        applyStimulus(0, 0, 0, 2, 0, 32'h8000, 0);
        checkOutput("rd1_pc_f", PC_F, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("rd2_pc_f",  PC_F, 32'h3000);
        checkOutput("rd2_ir_d",  IR_D, 32'h0);
        checkOutput("rd2_valid", {31'd0, valid_D}, 32'd0);
        checkOutput("rd2_pc4_d", PC4_D, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd3_pc_f", PC_F, 32'h3000);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("rd4_ir_d", IR_D, 32'h3000);
        checkOutput("rd4_pc_f", PC_F, 32'h3004);

        // Reset with the instruction buffer full
        applyStimulus(0, 1, 0, 0, 0, 0, 1);
        checkOutput("rb1_req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("rb2_pc_f", PC_F, 32'h3000);
        checkOutput("rb2_req",  {31'd0, imem_req}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("rb3_ir_d", IR_D, 32'h3000);
        checkOutput("rb3_pc_f", PC_F, 32'h3004);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
